// File: rtl/multibyte_add_seq_pkg.sv
// Shared definitions for the byte-serial multi-byte add/subtract sequencer.
//   BYTE_W   : width of one adder slice
//   state_t  : sequencer FSM states
//   ovf_term : two's-complement overflow from the MSB slice of the adder
package multibyte_add_seq_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Carry into bit 7 is recovered as a7^b7^s7; overflow is that carry XOR carry-out.
  function automatic logic ovf_term(input logic a7, input logic b7,
                                    input logic s7, input logic cout);
    return a7 ^ b7 ^ s7 ^ cout;
  endfunction

endpackage

// File: rtl/multibyte_add_seq.sv
// Byte-serial sequencer performing NBYTES*8-bit add/subtract on an external
// combinational 8-bit adder. Operands arrive over valid/ready, are fed to the
// adder one byte per cycle LSB first with the carry chained, and the assembled
// result is returned over valid/ready.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand handshake; in_a, in_b, in_cin, in_sub
//   out_valid/out_ready      result handshake; out_sum, out_cout, out_ovf
//   add_a/add_b/add_cin      drive the external adder (add_b pre-inverted for SUB)
//   add_sum/add_cout         combinational return from the external adder
module multibyte_add_seq
  import multibyte_add_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*NBYTES-1:0]      in_a,
  input  logic [8*NBYTES-1:0]      in_b,
  input  logic                     in_cin,
  input  logic                     in_sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*NBYTES-1:0]      out_sum,
  output logic                     out_cout,
  output logic                     out_ovf,
  output logic [BYTE_W-1:0]        add_a,
  output logic [BYTE_W-1:0]        add_b,
  output logic                     add_cin,
  input  logic [BYTE_W-1:0]        add_sum,
  input  logic                     add_cout
);

  localparam int unsigned W  = BYTE_W * NBYTES;
  localparam int unsigned CW = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  state_t          state;
  logic [W-1:0]    opa;
  logic [W-1:0]    opb;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic            accept;

  assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  assign add_a   = (state == ST_RUN) ? opa[BYTE_W-1:0] : '0;
  assign add_b   = (state == ST_RUN) ? opb[BYTE_W-1:0] : '0;
  assign add_cin = (state == ST_RUN) ? carry : 1'b0;

  // Operands shift right one byte per cycle; the result shifts in from the top,
  // so after NBYTES cycles byte 0 has reached the LSB position of out_sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      opa       <= '0;
      opb       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          opa     <= {{BYTE_W{1'b0}}, opa[W-1:BYTE_W]};
          opb     <= {{BYTE_W{1'b0}}, opb[W-1:BYTE_W]};
          out_sum <= {add_sum, out_sum[W-1:BYTE_W]};
          carry   <= add_cout;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            out_cout  <= add_cout;
            out_ovf   <= ovf_term(add_a[BYTE_W-1], add_b[BYTE_W-1],
                                  add_sum[BYTE_W-1], add_cout);
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Accept overrides the DONE->IDLE move so a new op starts with no bubble.
      if (accept) begin
        opa   <= in_a;
        opb   <= in_sub ? ~in_b : in_b;
        carry <= in_sub | in_cin;
        cnt   <= '0;
        state <= ST_RUN;
      end
    end
  end

endmodule
